pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the per-stage hand-written D/E, E/M and M/W latches with one configurable block. Carries instruction word, PC, N_OPND operand words, destination register, write enable, exception code and branch-delay flag. Supports four update modes: flush, hold, bubble and load. Tracks how long the current content has been held, and can optionally count stall events for performance analysis.

---
 rtl/pipe_stage_reg.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - configurable inter-stage pipeline register with flush/hold/bubble/load modes
// Optional stall/hold performance counters are enabled with PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
   parameter int XLEN    = 32,
   parameter int N_OPND  = 4,
   parameter int EXC_W   = 5,
   parameter int RI_CODE = 10,
   parameter int AGE_W   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   hold,
   input  logic                   stall,
   input  logic                   cnt_clr,
   input  logic                   in_valid,
   input  logic [XLEN-1:0]        in_instr,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [N_OPND*XLEN-1:0] in_opnd,
   input  logic [4:0]             in_reg_addr,
   input  logic                   in_reg_write,
   input  logic [EXC_W-1:0]       in_exc_code,
   input  logic                   in_bd,
   output logic                   out_valid,
   output logic [XLEN-1:0]        out_instr,
   output logic [XLEN-1:0]        out_pc,
   output logic [N_OPND*XLEN-1:0] out_opnd,
   output logic [4:0]             out_reg_addr,
   output logic                   out_reg_write,
   output logic [EXC_W-1:0]       out_exc_code,
   output logic                   out_bd,
   output logic [AGE_W-1:0]       out_age,
   output logic [31:0]            bubble_cnt,
   output logic [31:0]            hold_cnt
);

   localparam logic [EXC_W-1:0] RI = EXC_W'(RI_CODE);

   logic                   valid_q, valid_d;
   logic [XLEN-1:0]        instr_q, instr_d;
   logic [XLEN-1:0]        pc_q, pc_d;
   logic [N_OPND*XLEN-1:0] opnd_q, opnd_d;
   logic [4:0]             addr_q, addr_d;
   logic                   we_q, we_d;
   logic [EXC_W-1:0]       exc_q, exc_d;
   logic                   bd_q, bd_d;
   logic [AGE_W-1:0]       age_q, age_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      opnd_d  = opnd_q;
      addr_d  = addr_q;
      we_d    = we_q;
      exc_d   = exc_q;
      bd_d    = bd_q;
      age_d   = age_q;
      if (flush) begin
         valid_d = 1'b0;
         instr_d = '0;
         pc_d    = '0;
         opnd_d  = '0;
         addr_d  = '0;
         we_d    = 1'b0;
         exc_d   = '0;
         bd_d    = 1'b0;
         age_d   = '0;
      end else if (hold) begin
         if (age_q != {AGE_W{1'b1}}) age_d = age_q + 1'b1;
      end else if (stall) begin
         // bubble keeps PC/BD so a later exception still reports the right EPC
         valid_d = 1'b0;
         instr_d = '0;
         pc_d    = in_pc;
         opnd_d  = '0;
         addr_d  = '0;
         we_d    = 1'b0;
         exc_d   = '0;
         bd_d    = in_bd;
         age_d   = '0;
      end else begin
         valid_d = in_valid;
         instr_d = (in_exc_code == RI) ? '0 : in_instr;
         pc_d    = in_pc;
         opnd_d  = in_opnd;
         addr_d  = in_reg_addr;
         we_d    = (in_exc_code != '0) ? 1'b0 : in_reg_write;
         exc_d   = in_exc_code;
         bd_d    = in_bd;
         age_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         opnd_q  <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         exc_q   <= '0;
         bd_q    <= 1'b0;
         age_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         opnd_q  <= opnd_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         exc_q   <= exc_d;
         bd_q    <= bd_d;
         age_q   <= age_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_instr     = instr_q;
   assign out_pc        = pc_q;
   assign out_opnd      = opnd_q;
   assign out_reg_addr  = addr_q;
   assign out_reg_write = we_q;
   assign out_exc_code  = exc_q;
   assign out_bd        = bd_q;
   assign out_age       = age_q;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] bub_q, bub_d;
   logic [31:0] hld_q, hld_d;

   always_comb begin
      bub_d = bub_q;
      hld_d = hld_q;
      if (cnt_clr) begin
         bub_d = '0;
         hld_d = '0;
      end else if (!flush) begin
         if (hold && hld_q != 32'hFFFF_FFFF) hld_d = hld_q + 32'd1;
         if (!hold && stall && bub_q != 32'hFFFF_FFFF) bub_d = bub_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bub_q <= '0;
         hld_q <= '0;
      end else begin
         bub_q <= bub_d;
         hld_q <= hld_d;
      end
   end

   assign bubble_cnt = bub_q;
   assign hold_cnt   = hld_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign bubble_cnt     = '0;
   assign hold_cnt       = '0;
`endif

endmodule
